// File: rtl/apb_ucpd_pkg.sv
// Shared types and constants for the UCPD receive path: framing FSM states,
// byte-counter width and its saturating increment.
package apb_ucpd_pkg;

  typedef enum logic [1:0] {
    RXB_IDLE = 2'd0,
    RXB_RECV = 2'd1,
    RXB_DROP = 2'd2
  } rxb_state_t;

  localparam int UCPD_RXCNT_W = 10;
  localparam logic [UCPD_RXCNT_W-1:0] UCPD_RXCNT_MAX = 10'd1023;

  // Message byte counter sticks at its maximum instead of wrapping.
  function automatic logic [UCPD_RXCNT_W-1:0] rxcnt_sat_inc(
    input logic [UCPD_RXCNT_W-1:0] c
  );
    return (c == UCPD_RXCNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/apb_ucpd_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is honoured only
// when a pop happens in the same cycle.
module apb_ucpd_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents after a flush are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_ucpd_rx_buf.sv
// UCPD receive buffer: frames decoded bytes per message into a FIFO read by
// RXDR pops. Optional DMA request level built when UCPD_RXDMA_EN is defined.
module apb_ucpd_rx_buf
  import apb_ucpd_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    ic_clk,
  input  logic                    ic_rst,
  input  logic                    ucpden,
  input  logic                    rx_msg_start,
  input  logic                    rx_byte_we,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_msg_end,
  input  logic                    rx_crc_ok,
  input  logic                    rxdr_rd,
  input  logic                    rx_ovr_clr,
  input  logic                    rx_msgend_clr,
  output logic [7:0]              rxdr,
  output logic                    rxne,
  output logic                    rx_ovr,
  output logic                    rx_msgend,
  output logic                    rx_err,
  output logic [UCPD_RXCNT_W-1:0] rx_msg_cnt,
  output logic                    rx_dma_req
);

  // All inputs from the decoder and the register file are single-cycle
  // pulses with no back-pressure: a pulse is acted on in the cycle it is high.

  rxb_state_t              state;
  logic [UCPD_RXCNT_W-1:0] byte_cnt;
  logic [UCPD_RXCNT_W-1:0] cnt_inc;
  logic                    flush;
  logic                    byte_in_recv;
  logic                    fifo_push;
  logic                    ovr_event;
  logic [7:0]              fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [AW:0]             fifo_count;

  assign flush = ic_rst || !ucpden;

  apb_ucpd_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (ic_clk),
    .flush (flush),
    .push  (fifo_push),
    .wdata (rx_byte),
    .pop   (rxdr_rd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rxne = (fifo_count != '0);
  assign rxdr = rxne ? fifo_rdata : 8'h00;

  // A restarting SOP wins over a byte strobed in the same cycle.
  always_comb begin
    byte_in_recv = (state == RXB_RECV) && rx_byte_we && !rx_msg_start;
    ovr_event    = byte_in_recv && fifo_full && !(rxdr_rd && !fifo_empty);
    fifo_push    = byte_in_recv && !ovr_event;
    cnt_inc      = rxcnt_sat_inc(byte_cnt);
  end

  always_ff @(posedge ic_clk) begin
    if (flush) begin
      state      <= RXB_IDLE;
      byte_cnt   <= '0;
      rx_ovr     <= 1'b0;
      rx_msgend  <= 1'b0;
      rx_err     <= 1'b0;
      rx_msg_cnt <= '0;
    end else begin
      rx_ovr <= ovr_event || (rx_ovr && !rx_ovr_clr);
      // Clear first; a message end below in the same cycle overrides it.
      if (rx_msgend_clr) begin
        rx_msgend <= 1'b0;
        rx_err    <= 1'b0;
      end
      case (state)
        RXB_IDLE: begin
          if (rx_msg_start) begin
            state    <= RXB_RECV;
            byte_cnt <= '0;
          end
        end
        RXB_RECV: begin
          if (rx_msg_start) begin
            byte_cnt <= '0;
          end else begin
            if (rx_byte_we) byte_cnt <= cnt_inc;
            if (rx_msg_end) begin
              rx_msgend  <= 1'b1;
              rx_err     <= !rx_crc_ok || ovr_event;
              rx_msg_cnt <= rx_byte_we ? cnt_inc : byte_cnt;
              state      <= RXB_IDLE;
            end else if (ovr_event) begin
              state <= RXB_DROP;
            end
          end
        end
        RXB_DROP: begin
          if (rx_msg_start) begin
            state    <= RXB_RECV;
            byte_cnt <= '0;
          end else begin
            if (rx_byte_we) byte_cnt <= cnt_inc;
            if (rx_msg_end) begin
              rx_msgend  <= 1'b1;
              rx_err     <= 1'b1;
              rx_msg_cnt <= rx_byte_we ? cnt_inc : byte_cnt;
              state      <= RXB_IDLE;
            end
          end
        end
        default: state <= RXB_IDLE;
      endcase
    end
  end

`ifdef UCPD_RXDMA_EN
  logic dma_q;

  always_ff @(posedge ic_clk) begin
    if (flush) dma_q <= 1'b0;
    else       dma_q <= rxne && !rx_ovr;
  end

  assign rx_dma_req = dma_q;
`else
  assign rx_dma_req = 1'b0;
`endif

endmodule

// File: tb/tb_apb_ucpd_rx_buf.sv
// Directed self-checking bench for apb_ucpd_rx_buf (DEPTH=8); the DMA
// scenario follows UCPD_RXDMA_EN.
module tb_apb_ucpd_rx_buf;

  logic       ic_clk;
  logic       ic_rst;
  logic       ucpden;
  logic       rx_msg_start;
  logic       rx_byte_we;
  logic [7:0] rx_byte;
  logic       rx_msg_end;
  logic       rx_crc_ok;
  logic       rxdr_rd;
  logic       rx_ovr_clr;
  logic       rx_msgend_clr;
  logic [7:0] rxdr;
  logic       rxne;
  logic       rx_ovr;
  logic       rx_msgend;
  logic       rx_err;
  logic [9:0] rx_msg_cnt;
  logic       rx_dma_req;

  int checks = 0;
  int errors = 0;

  apb_ucpd_rx_buf #(.DEPTH(8)) dut (
    .ic_clk        (ic_clk),
    .ic_rst        (ic_rst),
    .ucpden        (ucpden),
    .rx_msg_start  (rx_msg_start),
    .rx_byte_we    (rx_byte_we),
    .rx_byte       (rx_byte),
    .rx_msg_end    (rx_msg_end),
    .rx_crc_ok     (rx_crc_ok),
    .rxdr_rd       (rxdr_rd),
    .rx_ovr_clr    (rx_ovr_clr),
    .rx_msgend_clr (rx_msgend_clr),
    .rxdr          (rxdr),
    .rxne          (rxne),
    .rx_ovr        (rx_ovr),
    .rx_msgend     (rx_msgend),
    .rx_err        (rx_err),
    .rx_msg_cnt    (rx_msg_cnt),
    .rx_dma_req    (rx_dma_req)
  );

  // Clock / reset
  initial ic_clk = 1'b0;
  always #5 ic_clk = ~ic_clk;

  // Driver tasks: inputs set before the edge, outputs read 1 time unit after.
  task automatic clk1();
    @(posedge ic_clk);
    #1;
    rx_msg_start  = 1'b0;
    rx_byte_we    = 1'b0;
    rx_msg_end    = 1'b0;
    rxdr_rd       = 1'b0;
    rx_ovr_clr    = 1'b0;
    rx_msgend_clr = 1'b0;
  endtask

  task automatic sop();
    rx_msg_start = 1'b1;
    clk1();
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_byte_we = 1'b1;
    rx_byte    = b;
    clk1();
  endtask

  task automatic eop(input logic crc);
    rx_msg_end = 1'b1;
    rx_crc_ok  = crc;
    clk1();
  endtask

  task automatic pop();
    rxdr_rd = 1'b1;
    clk1();
  endtask

  task automatic clear_flags();
    rx_ovr_clr    = 1'b1;
    rx_msgend_clr = 1'b1;
    clk1();
  endtask

  task automatic test_reset();
    ic_rst = 1'b1;
    clk1();
    clk1();
    ic_rst = 1'b0;
    checks++; if (rxdr !== 8'h00) begin errors++; $display("FAIL reset_rxdr: got %h exp 00", rxdr); end
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL reset_rxne: got %b exp 0", rxne); end
    checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b exp 0", rx_ovr); end
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL reset_msgend: got %b exp 0", rx_msgend); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", rx_err); end
    checks++; if (rx_msg_cnt !== 10'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", rx_msg_cnt); end
    checks++; if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL reset_dma: got %b exp 0", rx_dma_req); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    sop();
    push_byte(8'h11);
    checks++; if (rxne !== 1'b1 || rxdr !== 8'h11) begin errors++; $display("FAIL basic_push_latency: got rxne=%b rxdr=%h exp 1/11", rxne, rxdr); end
    push_byte(8'h22);
    push_byte(8'h33);
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL basic_msgend_early: got %b exp 0", rx_msgend); end
    eop(1'b1);
    checks++; if (rx_msgend !== 1'b1) begin errors++; $display("FAIL basic_msgend: got %b exp 1", rx_msgend); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b exp 0", rx_err); end
    checks++; if (rx_msg_cnt !== 10'd3) begin errors++; $display("FAIL basic_cnt: got %0d exp 3", rx_msg_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rxdr !== exp_b[i]) begin errors++; $display("FAIL basic_pop%0d: got %h exp %h", i, rxdr, exp_b[i]); end
      pop();
    end
    checks++; if (rxne !== 1'b0 || rxdr !== 8'h00) begin errors++; $display("FAIL basic_empty: got rxne=%b rxdr=%h exp 0/00", rxne, rxdr); end
    pop();
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL basic_underflow: got rxne=%b exp 0", rxne); end
    rx_msgend_clr = 1'b1;
    clk1();
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL basic_msgend_clr: got %b exp 0", rx_msgend); end
  endtask

  task automatic test_overrun();
    sop();
    for (int i = 1; i <= 10; i++) begin
      push_byte(8'h40 + 8'(i));
      if (i == 8) begin
        checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL ovr_at8: got %b exp 0", rx_ovr); end
      end
      if (i == 9) begin
        checks++; if (rx_ovr !== 1'b1) begin errors++; $display("FAIL ovr_at9: got %b exp 1", rx_ovr); end
      end
    end
    eop(1'b1);
    checks++; if (rx_msgend !== 1'b1 || rx_err !== 1'b1) begin errors++; $display("FAIL ovr_status: got msgend=%b err=%b exp 1/1", rx_msgend, rx_err); end
    checks++; if (rx_msg_cnt !== 10'd10) begin errors++; $display("FAIL ovr_cnt: got %0d exp 10", rx_msg_cnt); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (rxdr !== 8'h40 + 8'(i)) begin errors++; $display("FAIL ovr_data%0d: got %h exp %h", i, rxdr, 8'h40 + 8'(i)); end
      pop();
    end
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b exp 0", rxne); end
    clear_flags();
    checks++; if (rx_ovr !== 1'b0 || rx_msgend !== 1'b0 || rx_err !== 1'b0) begin errors++; $display("FAIL ovr_clear: got ovr=%b msgend=%b err=%b exp 0/0/0", rx_ovr, rx_msgend, rx_err); end
  endtask

  task automatic test_full_push_pop();
    sop();
    for (int i = 1; i <= 8; i++) push_byte(8'h60 + 8'(i));
    rx_byte_we = 1'b1;
    rx_byte    = 8'hA5;
    rxdr_rd    = 1'b1;
    clk1();
    checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL full_pp_ovr: got %b exp 0", rx_ovr); end
    checks++; if (rxdr !== 8'h62) begin errors++; $display("FAIL full_pp_head: got %h exp 62", rxdr); end
    // End of message and its clear in the same cycle: flag must stay set.
    rx_msgend_clr = 1'b1;
    eop(1'b1);
    checks++; if (rx_msgend !== 1'b1 || rx_err !== 1'b0) begin errors++; $display("FAIL full_pp_set_clr: got msgend=%b err=%b exp 1/0", rx_msgend, rx_err); end
    checks++; if (rx_msg_cnt !== 10'd9) begin errors++; $display("FAIL full_pp_cnt: got %0d exp 9", rx_msg_cnt); end
    for (int i = 2; i <= 8; i++) begin
      checks++; if (rxdr !== 8'h60 + 8'(i)) begin errors++; $display("FAIL full_pp_data%0d: got %h exp %h", i, rxdr, 8'h60 + 8'(i)); end
      pop();
    end
    checks++; if (rxdr !== 8'hA5) begin errors++; $display("FAIL full_pp_last: got %h exp a5", rxdr); end
    pop();
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL full_pp_empty: got %b exp 0", rxne); end
  endtask

  task automatic test_restart();
    clear_flags();
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL restart_pre: got %b exp 0", rx_msgend); end
    sop();
    push_byte(8'h01);
    push_byte(8'h02);
    sop();
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL restart_no_msgend: got %b exp 0", rx_msgend); end
    push_byte(8'h03);
    eop(1'b0);
    checks++; if (rx_msgend !== 1'b1 || rx_err !== 1'b1) begin errors++; $display("FAIL restart_status: got msgend=%b err=%b exp 1/1", rx_msgend, rx_err); end
    checks++; if (rx_msg_cnt !== 10'd1) begin errors++; $display("FAIL restart_cnt: got %0d exp 1", rx_msg_cnt); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (rxdr !== 8'(i)) begin errors++; $display("FAIL restart_data%0d: got %h exp %h", i, rxdr, 8'(i)); end
      pop();
    end
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL restart_empty: got %b exp 0", rxne); end
  endtask

  task automatic test_flush_reset();
    sop();
    push_byte(8'h77);
    ucpden = 1'b0;
    clk1();
    ucpden = 1'b1;
    checks++; if (rxne !== 1'b0 || rxdr !== 8'h00) begin errors++; $display("FAIL flush_fifo: got rxne=%b rxdr=%h exp 0/00", rxne, rxdr); end
    checks++; if (rx_msgend !== 1'b0 || rx_err !== 1'b0 || rx_msg_cnt !== 10'd0) begin errors++; $display("FAIL flush_status: got msgend=%b err=%b cnt=%0d exp 0/0/0", rx_msgend, rx_err, rx_msg_cnt); end
    eop(1'b1);
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL flush_eop_idle: got %b exp 0", rx_msgend); end
    push_byte(8'h99);
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL flush_byte_idle: got %b exp 0", rxne); end
    sop();
    push_byte(8'h55);
    eop(1'b1);
    checks++; if (rx_msgend !== 1'b1 || rxne !== 1'b1) begin errors++; $display("FAIL rst_pre: got msgend=%b rxne=%b exp 1/1", rx_msgend, rxne); end
    ic_rst = 1'b1;
    clk1();
    ic_rst = 1'b0;
    checks++; if (rxne !== 1'b0 || rx_msgend !== 1'b0 || rx_msg_cnt !== 10'd0) begin errors++; $display("FAIL rst_status: got rxne=%b msgend=%b cnt=%0d exp 0/0/0", rxne, rx_msgend, rx_msg_cnt); end
    eop(1'b1);
    checks++; if (rx_msgend !== 1'b0) begin errors++; $display("FAIL rst_eop_idle: got %b exp 0", rx_msgend); end
  endtask

  task automatic test_saturate();
    sop();
    for (int i = 0; i < 1030; i++) push_byte(8'(i));
    eop(1'b1);
    checks++; if (rx_msg_cnt !== 10'd1023) begin errors++; $display("FAIL sat_cnt: got %0d exp 1023", rx_msg_cnt); end
    checks++; if (rx_err !== 1'b1 || rx_ovr !== 1'b1) begin errors++; $display("FAIL sat_err: got err=%b ovr=%b exp 1/1", rx_err, rx_ovr); end
    ucpden = 1'b0;
    clk1();
    ucpden = 1'b1;
    checks++; if (rx_ovr !== 1'b0 || rxne !== 1'b0) begin errors++; $display("FAIL sat_flush: got ovr=%b rxne=%b exp 0/0", rx_ovr, rxne); end
  endtask

  task automatic test_dma();
    sop();
    push_byte(8'h5A);
    checks++; if (rxne !== 1'b1 || rx_dma_req !== 1'b0) begin errors++; $display("FAIL dma_n1: got rxne=%b dma=%b exp 1/0", rxne, rx_dma_req); end
    clk1();
`ifdef UCPD_RXDMA_EN
    checks++; if (rx_dma_req !== 1'b1) begin errors++; $display("FAIL dma_n2: got %b exp 1", rx_dma_req); end
    pop();
    checks++; if (rxne !== 1'b0 || rx_dma_req !== 1'b1) begin errors++; $display("FAIL dma_after_pop: got rxne=%b dma=%b exp 0/1", rxne, rx_dma_req); end
    clk1();
    checks++; if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL dma_deassert: got %b exp 0", rx_dma_req); end
`else
    checks++; if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL dma_off: got %b exp 0", rx_dma_req); end
    pop();
    checks++; if (rxne !== 1'b0) begin errors++; $display("FAIL dma_off_pop: got %b exp 0", rxne); end
`endif
  endtask

  initial begin
    ic_rst        = 1'b1;
    ucpden        = 1'b1;
    rx_msg_start  = 1'b0;
    rx_byte_we    = 1'b0;
    rx_byte       = 8'h00;
    rx_msg_end    = 1'b0;
    rx_crc_ok     = 1'b0;
    rxdr_rd       = 1'b0;
    rx_ovr_clr    = 1'b0;
    rx_msgend_clr = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_restart();
    test_flush_reset();
    test_saturate();
    test_dma();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
